// File: rtl/pc_fetch_if.sv
// pc_fetch_if -- fetch-stage PC controller bus.
// Groups the execute-stage redirect inputs and the fetch-address/trap/perf
// outputs of pc_fetch_ctrl.
//   master : drives stall/redirect and observes PC, trap and counters (execute side / bench)
//   slave  : pc_fetch_ctrl itself
// Parameters: WIDTH (address width), CNT_W (perf counter width).
interface pc_fetch_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);
   logic             stall;
   logic             redir_valid;
   logic [WIDTH-1:0] redir_base;
   logic [WIDTH-1:0] redir_imm;
   logic             redir_jalr;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic             pc_valid;
   logic             trap;
   logic [WIDTH-1:0] trap_addr;
   logic [CNT_W-1:0] redir_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output stall, redir_valid, redir_base, redir_imm, redir_jalr,
      input  pc, pc_plus, pc_valid, trap, trap_addr, redir_cnt, stall_cnt
   );

   modport slave (
      input  stall, redir_valid, redir_base, redir_imm, redir_jalr,
      output pc, pc_plus, pc_valid, trap, trap_addr, redir_cnt, stall_cnt
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- program-counter generator for the fetch stage.
// Holds the fetch PC, steps it by ILEN, applies execute-stage redirects
// (base + imm, optional JALR bit-0 clear), buffers a redirect that arrives
// while stalled, and traps to TRAP_VEC on a misaligned target.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pc_fetch_if.slave
//            in : stall, redir_valid, redir_base, redir_imm, redir_jalr
//            out: pc, pc_plus (comb pc+ILEN), pc_valid, trap, trap_addr,
//                 redir_cnt, stall_cnt
// Optional feature: define PC_PERF_EN to build saturating redirect/stall
// counters; without it both counter outputs are tied to zero.
module pc_fetch_ctrl #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VEC  = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC   = 'h100,
   parameter int unsigned      ILEN       = 4,
   parameter int unsigned      ALIGN_BITS = 2,
   parameter int unsigned      CNT_W      = 16
) (
   input logic       clk,
   input logic       rst_n,
   pc_fetch_if.slave bus
);

   localparam logic [WIDTH-1:0] ILEN_W = WIDTH'(ILEN);

   typedef enum logic [1:0] {BOOT, RUN, PEND, TRAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] trap_addr_q, trap_addr_d;
   logic [WIDTH-1:0] tgt, apply_tgt;
   logic             misal, take;

   // Target of the current redirect; a fresh redirect overrides a buffered one.
   always_comb begin
      tgt = bus.redir_base + bus.redir_imm;
      if (bus.redir_jalr) tgt[0] = 1'b0;
      apply_tgt = bus.redir_valid ? tgt : pend_q;
      misal     = |apply_tgt[ALIGN_BITS-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_VEC;
         pend_q      <= '0;
         trap_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         trap_addr_q <= trap_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      trap_addr_d = trap_addr_q;
      take        = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
            pc_d    = RESET_VEC;
         end
         RUN: begin
            if (bus.redir_valid) begin
               if (bus.stall) begin
                  pend_d  = tgt;
                  state_d = PEND;
               end else begin
                  take = 1'b1;
               end
            end else if (!bus.stall) begin
               pc_d = pc_q + ILEN_W;
            end
         end
         PEND: begin
            if (bus.stall) begin
               if (bus.redir_valid) pend_d = tgt;
            end else begin
               take = 1'b1;
            end
         end
         TRAP: state_d = RUN;  // pc stays at TRAP_VEC for the first RUN cycle
         default: state_d = BOOT;
      endcase
      if (take) begin
         if (misal) begin
            state_d     = TRAP;
            pc_d        = TRAP_VEC;
            trap_addr_d = apply_tgt;
         end else begin
            state_d = RUN;
            pc_d    = apply_tgt;
         end
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus   = pc_q + ILEN_W;
   assign bus.pc_valid  = (state_q == RUN) || (state_q == PEND);
   assign bus.trap      = (state_q == TRAP);
   assign bus.trap_addr = trap_addr_q;

`ifdef PC_PERF_EN
   logic [CNT_W-1:0] redir_cnt_q, stall_cnt_q;
   logic             active;

   // Only RUN/PEND look at the inputs, so only they count.
   assign active = (state_q == RUN) || (state_q == PEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (active && bus.redir_valid && !(&redir_cnt_q))
            redir_cnt_q <= redir_cnt_q + CNT_W'(1);
         if (active && bus.stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign bus.redir_cnt = redir_cnt_q;
   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.redir_cnt = {CNT_W{1'b0}};
   assign bus.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl -- directed + random bench for pc_fetch_ctrl with a
// cycle-level reference model of the fetch PC rules.
module tb_pc_fetch_ctrl;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned CNT_W      = 2;
   localparam int unsigned ILEN       = 4;
   localparam int unsigned ALIGN_BITS = 2;
   localparam logic [31:0] RESET_VEC  = 32'h0;
   localparam logic [31:0] TRAP_VEC   = 32'h100;
   localparam int          CNT_MAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   pc_fetch_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   pc_fetch_ctrl #(
      .WIDTH(WIDTH), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC),
      .ILEN(ILEN), .ALIGN_BITS(ALIGN_BITS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: what the fetch stage should present after each edge.
   logic [31:0] m_pc, m_taddr;
   logic        m_valid, m_trap, m_boot;
   logic [31:0] m_pend[$];   // buffered redirects while stalled; last one wins
   int          m_rc, m_sc;

   task automatic model_reset();
      m_boot = 1'b1; m_valid = 1'b0; m_trap = 1'b0;
      m_pc = RESET_VEC; m_taddr = '0; m_pend.delete();
      m_rc = 0; m_sc = 0;
   endtask

   task automatic model_edge();
      logic [31:0] t, target;
      logic        have;
      t = bus.redir_base + bus.redir_imm;
      if (bus.redir_jalr) t = t & ~32'h1;
      if (m_boot) begin
         m_boot = 1'b0; m_valid = 1'b1; m_pc = RESET_VEC;
      end else if (m_trap) begin
         m_trap = 1'b0; m_valid = 1'b1;
      end else begin
         if (bus.redir_valid && m_rc < CNT_MAX) m_rc++;
         if (bus.stall && m_sc < CNT_MAX) m_sc++;
         if (bus.stall) begin
            if (bus.redir_valid) m_pend.push_back(t);
         end else begin
            have   = bus.redir_valid || (m_pend.size() > 0);
            target = bus.redir_valid ? t : (m_pend.size() > 0 ? m_pend[$] : 32'h0);
            m_pend.delete();
            if (!have)
               m_pc = m_pc + ILEN;
            else if ((target % (32'h1 << ALIGN_BITS)) != 0) begin
               m_trap = 1'b1; m_valid = 1'b0; m_pc = TRAP_VEC; m_taddr = target;
            end else
               m_pc = target;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},        bus.pc,                 m_pc);
      chk({tag, ".pc_plus"},   bus.pc_plus,            m_pc + ILEN);
      chk({tag, ".pc_valid"},  32'(bus.pc_valid),      32'(m_valid));
      chk({tag, ".trap"},      32'(bus.trap),          32'(m_trap));
      chk({tag, ".trap_addr"}, bus.trap_addr,          m_taddr);
`ifdef PC_PERF_EN
      chk({tag, ".redir_cnt"}, 32'(bus.redir_cnt),     32'(m_rc));
      chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt),     32'(m_sc));
`else
      chk({tag, ".redir_cnt"}, 32'(bus.redir_cnt),     32'h0);
      chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt),     32'h0);
`endif
   endtask

   task automatic drive(input logic s, input logic rv, input logic [31:0] base,
                        input logic [31:0] imm, input logic jalr);
      bus.stall = s; bus.redir_valid = rv; bus.redir_base = base;
      bus.redir_imm = imm; bus.redir_jalr = jalr;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] base, imm;
      // reset state
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #2 check_all("reset");
      chk("reset.pc_const", bus.pc, 32'h0);
      #10 rst_n = 1'b1;

      // boot and sequential stepping
      step("boot");
      chk("boot.valid", 32'(bus.pc_valid), 32'h1);
      step("seq4");
      chk("seq4.pc", bus.pc, 32'h4);
      step("seq8");
      chk("seq8.pc", bus.pc, 32'h8);

      // backward branch 8 + (-8) -> 0
      drive(0, 1, 32'h8, 32'hFFFF_FFF8, 0);
      step("br0");
      chk("br0.pc", bus.pc, 32'h0);
      drive(0, 0, 0, 0, 0);
      step("br4");
      chk("br4.pc", bus.pc, 32'h4);

      // JALR to 0x203 -> 0x202, misaligned -> trap
      drive(0, 1, 32'h203, 32'h0, 1);
      step("trap");
      chk("trap.pulse", 32'(bus.trap), 32'h1);
      chk("trap.addr", bus.trap_addr, 32'h202);
      chk("trap.pc", bus.pc, 32'h100);
      drive(1, 1, 32'h40, 0, 0);   // ignored during the trap cycle
      step("post_trap");
      chk("post_trap.pc", bus.pc, 32'h100);
      chk("post_trap.valid", 32'(bus.pc_valid), 32'h1);
      drive(0, 0, 0, 0, 0);
      step("post_trap2");

      // stall with two buffered redirects; last one applies after stall drops
      drive(1, 1, 32'h40, 0, 0);
      step("pend1");
      drive(1, 1, 32'h80, 0, 0);
      step("pend2");
      drive(1, 0, 0, 0, 0);
      step("pend3");
      chk("pend3.pc_frozen", bus.pc, 32'h104);
      drive(0, 0, 0, 0, 0);
      step("pend_apply");
      chk("pend_apply.pc", bus.pc, 32'h80);

      // wrap at top of address space
      drive(0, 1, 32'hFFFF_FFFC, 0, 0);
      step("top");
      chk("top.pc_plus", bus.pc_plus, 32'h0);
      drive(0, 0, 0, 0, 0);
      step("wrap");
      chk("wrap.pc", bus.pc, 32'h0);
      step("wrap4");

      // reset while a redirect is pending discards it
      drive(1, 1, 32'h40, 0, 0);
      step("pend_rst");
      async_reset("rst_in_pend");
      chk("rst_in_pend.valid", 32'(bus.pc_valid), 32'h0);
      drive(0, 0, 0, 0, 0);
      step("rst_boot");
      step("rst_seq");
      chk("rst_seq.pc", bus.pc, 32'h4);

      // five redirects and four stalls: counters saturate at 3 with CNT_W=2
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 32'h10, 0, 0);
         step("perf_redir");
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 0);
         step("perf_stall");
      end
`ifdef PC_PERF_EN
      chk("perf.redir_cnt", 32'(bus.redir_cnt), 32'h3);
      chk("perf.stall_cnt", 32'(bus.stall_cnt), 32'h3);
`else
      chk("perf.redir_cnt", 32'(bus.redir_cnt), 32'h0);
      chk("perf.stall_cnt", 32'(bus.stall_cnt), 32'h0);
`endif

      // randomized traffic against the model, with occasional async resets
      for (int i = 0; i < 400; i++) begin
         base = $urandom & 32'hFFFF_FFFC;
         imm  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3))
                                             : 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 3) == 0) base = base | 32'h1;
         drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, base, imm,
               $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
         step("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Parametrised program-counter generator for the fetch stage, and the next generation of the two-way PC-next mux plus register. It adds pipeline stall, absolute (register-based) jump targets, and redirect buffering while stalled. It also adds misaligned-target trapping and an optional performance-counter block. It drives the instruction-memory address and takes redirects from the execute stage.

## Interface
- WIDTH, 32, address/PC width in bits
- RESET_VEC, 0, PC value loaded by reset (WIDTH bits)
- TRAP_VEC, 'h100, PC loaded on misaligned-target trap (WIDTH bits)
- ILEN, 4, sequential increment in bytes
- ALIGN_BITS, 2, low target bits that must be zero (1..4)
- CNT_W, 16, perf counter width (used only with PC_PERF_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC this cycle
- redir_valid  in  1  execute stage requests a PC change
- redir_base  in  WIDTH  target base: branch PC or rs1
- redir_imm  in  WIDTH  target offset (sign-extended by the producer)
- redir_jalr  in  1  clear bit 0 of the computed target
- pc  out  WIDTH  current fetch address (registered)
- pc_plus  out  WIDTH  pc + ILEN, combinational from pc
- pc_valid  out  1  pc is a legal fetch address this cycle
- trap  out  1  one-cycle misaligned-target pulse
- trap_addr  out  WIDTH  offending target, held until the next trap
- redir_cnt  out  CNT_W  accepted redirects (PC_PERF_EN only)
- stall_cnt  out  CNT_W  stalled cycles (PC_PERF_EN only)

## Operation
- Target computation:
  - tgt = redir_base + redir_imm, modulo 2^WIDTH.
  - If redir_jalr, tgt[0] = 0.
  - tgt is misaligned if tgt[ALIGN_BITS-1:0] != 0, checked after the bit-0 clear.
- Sequential next PC: pc + ILEN, wrapping modulo 2^WIDTH (all-ones region wraps to 0, no flag).
- States: BOOT, RUN, PEND, TRAP.
- Reset (async, any state):
  - state = BOOT, pc = RESET_VEC, pc_valid = 0.
  - trap = 0, trap_addr = 0, pending register cleared, counters = 0.
- BOOT:
  - Next edge goes to RUN with pc = RESET_VEC.
  - Inputs are ignored.
- RUN, priority redir_valid > stall > sequential:
  - redir_valid & !stall & aligned: pc <= tgt, stay RUN.
  - redir_valid & !stall & misaligned: pc <= TRAP_VEC, trap_addr <= tgt, go to TRAP.
  - redir_valid & stall: latch tgt into the pending register, pc held, go to PEND.
  - stall only: pc held.
  - Otherwise: pc <= pc + ILEN.
- PEND:
  - pc is held.
  - A new redir_valid overwrites the pending target (last one wins).
  - On the first cycle with stall = 0, the pending target is applied. If redir_valid is also present that cycle, its target is used instead.
  - Aligned: go to RUN with pc = target. Misaligned: TRAP path as in RUN.
- TRAP:
  - Lasts exactly one cycle: trap = 1, pc = TRAP_VEC, pc_valid = 0.
  - redir_valid and stall are ignored.
  - Next edge goes to RUN with pc still TRAP_VEC. That PC is not incremented by the trap cycle.
- pc_valid = 1 in RUN and PEND, 0 in BOOT and TRAP.

## Timing
- All outputs are registered except pc_plus.
- Redirect at cycle N with stall = 0: pc = tgt at N+1.
- Redirect at N with stall high during N..M: pc = tgt at M+2, i.e. one edge after stall falls at M+1.
- Misaligned redirect at N: trap = 1 and pc = TRAP_VEC at N+1; trap = 0 and pc_valid = 1 at N+2.
- After rst_n deassertion: first edge gives pc_valid = 1, pc = RESET_VEC; second edge gives pc = RESET_VEC + ILEN if not stalled.
- Reset asserted mid-PEND or mid-TRAP discards the pending target and the trap immediately (asynchronous).

## Configuration
- PC_PERF_EN defined:
  - redir_cnt increments on each accepted redirect, including ones that trap and ones overwritten in PEND.
  - stall_cnt increments each cycle with stall = 1 in RUN or PEND.
  - Both counters saturate at all-ones.
- PC_PERF_EN undefined: redir_cnt and stall_cnt are tied to 0, no counter flops exist, and CNT_W is unused.

## Test plan
- Reset release with stall = 0, defaults: pc sequence 0 (valid = 0), 0, 4, 8, 12.
- In RUN at pc = 8, redir_base = 8, redir_imm = 'hFFFFFFF8 -> pc = 0 next cycle, then 4.
- redir_jalr = 1, base = 'h203, imm = 0 -> tgt 'h202 is misaligned -> trap = 1 for one cycle, pc = 'h100, trap_addr = 'h202; next cycle pc = 'h100 with pc_valid = 1.
- stall high 3 cycles with a redirect to 'h40 in cycle 1 and a redirect to 'h80 in cycle 2 -> pc frozen, then pc = 'h80 one edge after stall falls.
- pc = 'hFFFFFFFC, no stall -> pc = 0 next cycle; rst_n pulsed low while in PEND -> pc = RESET_VEC at once and the pending target is never applied.
- PC_PERF_EN with CNT_W = 2: five redirects and four stall cycles -> redir_cnt = 3, stall_cnt = 3 (saturated).
